// File: rtl/battle_controller.sv
// battle_controller: turn sequencer for one three-versus-three battle.
// Tracks active combatants and their HP, reads moves from keycodes and paces enemy attacks.
module battle_controller #(
    parameter int DELAY_FRAMES = 30,
    parameter int HP_BASE      = 40,
    parameter int HP_STEP      = 8,
    parameter int DMG_BASE     = 8,
    parameter int DMG_STEP     = 4
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            start_battle,
    input  logic            frame_tick,
    input  logic [7:0]      keycode,
    input  logic [2:0][2:0] my_team,
    input  logic [2:0][2:0] enemy_team,
    output logic [1:0]      my_cur,
    output logic [1:0]      enemy_cur,
    output logic [2:0]      enemy_cur_id,
    output logic [7:0]      my_hp,
    output logic [7:0]      enemy_hp,
    output logic [1:0]      move_sel,
    output logic            turn,
    output logic            end_battle,
    output logic            result
);

    localparam logic [7:0]  KEY_A     = 8'h04;
    localparam logic [7:0]  KEY_D     = 8'h07;
    localparam logic [7:0]  KEY_ENTER = 8'h28;
    localparam logic [15:0] DELAY_W   = 16'(DELAY_FRAMES);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_LOAD  = 4'd1,
        S_SEL   = 4'd2,
        S_HIT_E = 4'd3,
        S_CHK_E = 4'd4,
        S_WAIT  = 4'd5,
        S_HIT_P = 4'd6,
        S_CHK_P = 4'd7,
        S_DONE  = 4'd8
    } state_t;

    state_t      state_r, state_n;
    logic [1:0]  my_cur_r, my_cur_n;
    logic [1:0]  enemy_cur_r, enemy_cur_n;
    logic [1:0]  move_sel_r, move_sel_n;
    logic [7:0]  my_hp_r, my_hp_n;
    logic [7:0]  enemy_hp_r, enemy_hp_n;
    logic        result_r, result_n;
    logic        turn_r, turn_n;
    logic        end_battle_r, end_battle_n;
    logic [15:0] frame_cnt_r, frame_cnt_n;
    logic [7:0]  lfsr_r;
    logic [7:0]  prev_key_r;
    logic        key_press_s;

    function automatic logic [7:0] base_hp(input logic [2:0] id);
        return 8'(HP_BASE) + 8'(HP_STEP) * {5'd0, id};
    endfunction

    function automatic logic [7:0] dmg(input logic [1:0] mv);
        return 8'(DMG_BASE) + 8'(DMG_STEP) * {6'd0, mv};
    endfunction

    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : 8'd0;
    endfunction

    // x^8+x^6+x^5+x^4+1 in Fibonacci form, shifting towards the MSB
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [2:0] team_id(input logic [2:0][2:0] team, input logic [1:0] idx);
        case (idx)
            2'd0:    return team[0];
            2'd1:    return team[1];
            2'd2:    return team[2];
            default: return 3'd0;
        endcase
    endfunction

    assign key_press_s = (keycode != 8'h00) && (prev_key_r == 8'h00);

    // Free-running move generator and previous keycode for press detection.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            lfsr_r     <= 8'hA5;
            prev_key_r <= 8'h00;
        end else begin
            lfsr_r     <= lfsr_step(lfsr_r);
            prev_key_r <= keycode;
        end
    end

    // FSM state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next state plus next values of every battle register.
    always_comb begin
        state_n     = state_r;
        my_cur_n    = my_cur_r;
        enemy_cur_n = enemy_cur_r;
        move_sel_n  = move_sel_r;
        my_hp_n     = my_hp_r;
        enemy_hp_n  = enemy_hp_r;
        result_n    = result_r;
        frame_cnt_n = frame_cnt_r;
        case (state_r)
            S_IDLE: begin
                if (start_battle) begin
                    my_cur_n    = 2'd0;
                    enemy_cur_n = 2'd0;
                    move_sel_n  = 2'd0;
                    result_n    = 1'b0;
                    state_n     = S_LOAD;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_LOAD: begin
                my_hp_n    = base_hp(my_team[0]);
                enemy_hp_n = base_hp(enemy_team[0]);
                state_n    = S_SEL;
            end
            S_SEL: begin
                if (key_press_s) begin
                    case (keycode)
                        KEY_A:     move_sel_n = move_sel_r - 2'd1;
                        KEY_D:     move_sel_n = move_sel_r + 2'd1;
                        KEY_ENTER: state_n    = S_HIT_E;
                        default:   move_sel_n = move_sel_r;
                    endcase
                end else begin
                    move_sel_n = move_sel_r;
                end
            end
            S_HIT_E: begin
                enemy_hp_n = sat_sub(enemy_hp_r, dmg(move_sel_r));
                state_n    = S_CHK_E;
            end
            S_CHK_E: begin
                frame_cnt_n = 16'd0;
                if (enemy_hp_r != 8'd0) begin
                    state_n = S_WAIT;
                end else if (enemy_cur_r == 2'd2) begin
                    result_n = 1'b1;
                    state_n  = S_DONE;
                end else begin
                    enemy_cur_n = enemy_cur_r + 2'd1;
                    enemy_hp_n  = base_hp(team_id(enemy_team, enemy_cur_r + 2'd1));
                    state_n     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (frame_tick) begin
                    if ((frame_cnt_r + 16'd1) >= DELAY_W) begin
                        state_n = S_HIT_P;
                    end else begin
                        frame_cnt_n = frame_cnt_r + 16'd1;
                    end
                end else begin
                    frame_cnt_n = frame_cnt_r;
                end
            end
            S_HIT_P: begin
                my_hp_n = sat_sub(my_hp_r, dmg(lfsr_r[1:0]));
                state_n = S_CHK_P;
            end
            S_CHK_P: begin
                if (my_hp_r != 8'd0) begin
                    state_n = S_SEL;
                end else if (my_cur_r == 2'd2) begin
                    result_n = 1'b0;
                    state_n  = S_DONE;
                end else begin
                    my_cur_n = my_cur_r + 2'd1;
                    my_hp_n  = base_hp(team_id(my_team, my_cur_r + 2'd1));
                    state_n  = S_SEL;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        turn_n       = (state_n == S_WAIT) || (state_n == S_HIT_P) || (state_n == S_CHK_P);
        end_battle_n = (state_n == S_DONE);
    end

    // Battle registers; turn and end_battle are decoded from the next state so they align with it.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            my_cur_r     <= 2'd0;
            enemy_cur_r  <= 2'd0;
            move_sel_r   <= 2'd0;
            my_hp_r      <= 8'd0;
            enemy_hp_r   <= 8'd0;
            result_r     <= 1'b0;
            turn_r       <= 1'b0;
            end_battle_r <= 1'b0;
            frame_cnt_r  <= 16'd0;
        end else begin
            my_cur_r     <= my_cur_n;
            enemy_cur_r  <= enemy_cur_n;
            move_sel_r   <= move_sel_n;
            my_hp_r      <= my_hp_n;
            enemy_hp_r   <= enemy_hp_n;
            result_r     <= result_n;
            turn_r       <= turn_n;
            end_battle_r <= end_battle_n;
            frame_cnt_r  <= frame_cnt_n;
        end
    end

    assign my_cur       = my_cur_r;
    assign enemy_cur    = enemy_cur_r;
    assign enemy_cur_id = team_id(enemy_team, enemy_cur_r);
    assign my_hp        = my_hp_r;
    assign enemy_hp     = enemy_hp_r;
    assign move_sel     = move_sel_r;
    assign turn         = turn_r;
    assign end_battle   = end_battle_r;
    assign result       = result_r;

endmodule

// File: tb/tb_battle_controller.sv
// Directed testbench for battle_controller: whole battles with hand-computed HP values,
// with the enemy's move steered by timing the final frame tick against an LFSR model.
module tb_battle_controller;

    localparam int TB_DELAY = 3;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_ENTER = 8'h28;

    logic            Clk;
    logic            Reset;
    logic            start_battle;
    logic            frame_tick;
    logic [7:0]      keycode;
    logic [2:0][2:0] my_team;
    logic [2:0][2:0] enemy_team;
    logic [1:0]      my_cur;
    logic [1:0]      enemy_cur;
    logic [2:0]      enemy_cur_id;
    logic [7:0]      my_hp;
    logic [7:0]      enemy_hp;
    logic [1:0]      move_sel;
    logic            turn;
    logic            end_battle;
    logic            result;
    logic [7:0]      m_lfsr;
    int              n_cmp = 0;
    int              n_fail = 0;

    battle_controller #(.DELAY_FRAMES(TB_DELAY)) dut (
        .Clk(Clk), .Reset(Reset), .start_battle(start_battle), .frame_tick(frame_tick),
        .keycode(keycode), .my_team(my_team), .enemy_team(enemy_team),
        .my_cur(my_cur), .enemy_cur(enemy_cur), .enemy_cur_id(enemy_cur_id),
        .my_hp(my_hp), .enemy_hp(enemy_hp), .move_sel(move_sel), .turn(turn),
        .end_battle(end_battle), .result(result)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Reference LFSR, x^8+x^6+x^5+x^4+1 seeded with 8'hA5.
    always @(posedge Clk or posedge Reset) begin
        if (Reset) m_lfsr <= 8'hA5;
        else       m_lfsr <= lfsr_next(m_lfsr);
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic press_key(input logic [7:0] k);
        keycode = k; step();
        keycode = 8'h00; step();
    endtask

    // From WAIT: give the first ticks, then time the last one so HIT_P sees the wanted move. Ends in CHK_P.
    task automatic enemy_phase(input logic [1:0] want);
        logic [7:0] nxt;
        int guard;
        for (int i = 0; i < TB_DELAY - 1; i++) begin
            frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
        end
        guard = 0;
        nxt = lfsr_next(m_lfsr);
        while ((nxt[1:0] != want) && (guard < 600)) begin
            step(); guard++; nxt = lfsr_next(m_lfsr);
        end
        n_cmp++; if (guard >= 600) begin n_fail++; $display("FAIL lfsr_wait: got %0d cycles want < 600", guard); end
        frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
    endtask

    task automatic test_reset();
        Reset = 1'b1; start_battle = 1'b0; frame_tick = 1'b0; keycode = 8'h00;
        my_team = {3'd0, 3'd7, 3'd3}; enemy_team = {3'd0, 3'd2, 3'd1};
        repeat (2) @(posedge Clk);
        #1;
        n_cmp++; if ({my_cur, enemy_cur, move_sel} !== 6'd0) begin n_fail++; $display("FAIL rst_idx: got %0h want 0", {my_cur, enemy_cur, move_sel}); end
        n_cmp++; if ({my_hp, enemy_hp} !== 16'd0) begin n_fail++; $display("FAIL rst_hp: got %0h want 0", {my_hp, enemy_hp}); end
        n_cmp++; if ({turn, end_battle, result} !== 3'd0) begin n_fail++; $display("FAIL rst_flags: got %0b want 000", {turn, end_battle, result}); end
        Reset = 1'b0;
        step();
    endtask

    task automatic test_start();
        start_battle = 1'b1; step();
        start_battle = 1'b0; step();
        n_cmp++; if (my_hp !== 8'd64) begin n_fail++; $display("FAIL start_my_hp: got %0d want 64", my_hp); end
        n_cmp++; if (enemy_hp !== 8'd48) begin n_fail++; $display("FAIL start_enemy_hp: got %0d want 48", enemy_hp); end
        n_cmp++; if (turn !== 1'b0) begin n_fail++; $display("FAIL start_turn: got %0b want 0", turn); end
        n_cmp++; if (enemy_cur_id !== 3'd1) begin n_fail++; $display("FAIL start_enemy_id: got %0d want 1", enemy_cur_id); end
    endtask

    task automatic test_player_attack();
        press_key(KEY_D); press_key(KEY_D);
        n_cmp++; if (move_sel !== 2'd2) begin n_fail++; $display("FAIL atk_move_sel: got %0d want 2", move_sel); end
        press_key(KEY_ENTER);
        n_cmp++; if (enemy_hp !== 8'd32) begin n_fail++; $display("FAIL atk_enemy_hp: got %0d want 32", enemy_hp); end
        n_cmp++; if (turn !== 1'b0) begin n_fail++; $display("FAIL atk_turn_chk: got %0b want 0", turn); end
        step();
        n_cmp++; if (turn !== 1'b1) begin n_fail++; $display("FAIL atk_turn_wait: got %0b want 1", turn); end
        enemy_phase(2'd0);
        n_cmp++; if (my_hp !== 8'd56) begin n_fail++; $display("FAIL atk_my_hp: got %0d want 56", my_hp); end
        step();
        n_cmp++; if (turn !== 1'b0) begin n_fail++; $display("FAIL atk_turn_sel: got %0b want 0", turn); end
    endtask

    task automatic test_cursor();
        press_key(KEY_A);
        n_cmp++; if (move_sel !== 2'd1) begin n_fail++; $display("FAIL cur_a1: got %0d want 1", move_sel); end
        press_key(KEY_A); press_key(KEY_A);
        n_cmp++; if (move_sel !== 2'd3) begin n_fail++; $display("FAIL cur_wrap_a: got %0d want 3", move_sel); end
        keycode = KEY_D;
        repeat (20) step();
        keycode = 8'h00; step();
        n_cmp++; if (move_sel !== 2'd0) begin n_fail++; $display("FAIL cur_hold_d: got %0d want 0", move_sel); end
    endtask

    task automatic test_enemy_faint_win();
        press_key(KEY_ENTER);
        n_cmp++; if (enemy_hp !== 8'd24) begin n_fail++; $display("FAIL win_t2_ehp: got %0d want 24", enemy_hp); end
        step(); enemy_phase(2'd0);
        n_cmp++; if (my_hp !== 8'd48) begin n_fail++; $display("FAIL win_t2_mhp: got %0d want 48", my_hp); end
        step();
        press_key(KEY_D); press_key(KEY_D); press_key(KEY_ENTER);
        n_cmp++; if (enemy_hp !== 8'd8) begin n_fail++; $display("FAIL win_t3_ehp: got %0d want 8", enemy_hp); end
        step(); enemy_phase(2'd0); step();
        start_battle = 1'b1; step(); start_battle = 1'b0; step();
        n_cmp++; if ({my_hp, enemy_hp, move_sel} !== {8'd40, 8'd8, 2'd2}) begin n_fail++; $display("FAIL win_midstart: got %0h want %0h", {my_hp, enemy_hp, move_sel}, {8'd40, 8'd8, 2'd2}); end
        press_key(KEY_A); press_key(KEY_A); press_key(KEY_ENTER);
        n_cmp++; if (enemy_hp !== 8'd0) begin n_fail++; $display("FAIL win_faint0_hp: got %0d want 0", enemy_hp); end
        step();
        n_cmp++; if ({enemy_cur, enemy_cur_id, enemy_hp} !== {2'd1, 3'd2, 8'd56}) begin n_fail++; $display("FAIL win_switch1: got %0h want %0h", {enemy_cur, enemy_cur_id, enemy_hp}, {2'd1, 3'd2, 8'd56}); end
        enemy_phase(2'd0); step();
        press_key(KEY_D); press_key(KEY_D); press_key(KEY_D); press_key(KEY_ENTER);
        n_cmp++; if (enemy_hp !== 8'd36) begin n_fail++; $display("FAIL win_t5_ehp: got %0d want 36", enemy_hp); end
        step(); enemy_phase(2'd0); step();
        press_key(KEY_ENTER); step(); enemy_phase(2'd0); step();
        press_key(KEY_ENTER); step();
        n_cmp++; if ({enemy_cur, enemy_cur_id, enemy_hp} !== {2'd2, 3'd0, 8'd40}) begin n_fail++; $display("FAIL win_switch2: got %0h want %0h", {enemy_cur, enemy_cur_id, enemy_hp}, {2'd2, 3'd0, 8'd40}); end
        enemy_phase(2'd0);
        n_cmp++; if (my_hp !== 8'd8) begin n_fail++; $display("FAIL win_t7_mhp: got %0d want 8", my_hp); end
        step();
        press_key(KEY_ENTER);
        n_cmp++; if (enemy_hp !== 8'd20) begin n_fail++; $display("FAIL win_t8_ehp: got %0d want 20", enemy_hp); end
        step(); enemy_phase(2'd0);
        n_cmp++; if (my_hp !== 8'd0) begin n_fail++; $display("FAIL win_my_faint: got %0d want 0", my_hp); end
        step();
        n_cmp++; if ({my_cur, my_hp, turn} !== {2'd1, 8'd96, 1'b0}) begin n_fail++; $display("FAIL win_my_switch: got %0h want %0h", {my_cur, my_hp, turn}, {2'd1, 8'd96, 1'b0}); end
        press_key(KEY_ENTER);
        n_cmp++; if (end_battle !== 1'b0) begin n_fail++; $display("FAIL win_early_end: got %0b want 0", end_battle); end
        step();
        n_cmp++; if ({end_battle, result} !== 2'b11) begin n_fail++; $display("FAIL win_done: got %0b want 11", {end_battle, result}); end
        start_battle = 1'b1; step(); start_battle = 1'b0;
        n_cmp++; if (end_battle !== 1'b0) begin n_fail++; $display("FAIL win_pulse_len: got %0b want 0", end_battle); end
        step(); step();
        n_cmp++; if ({result, my_hp} !== {1'b1, 8'd96}) begin n_fail++; $display("FAIL win_done_start: got %0h want %0h", {result, my_hp}, {1'b1, 8'd96}); end
    endtask

    task automatic test_saturation_loss();
        logic [1:0] wants [7]   = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd3};
        logic [7:0] exp_chk [7] = '{8'd20, 8'd0, 8'd20, 8'd0, 8'd20, 8'd4, 8'd0};
        logic [1:0] exp_cur [7] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
        logic [7:0] exp_sel [7] = '{8'd20, 8'd40, 8'd20, 8'd40, 8'd20, 8'd4, 8'd0};
        my_team = {3'd0, 3'd0, 3'd0}; enemy_team = {3'd0, 3'd0, 3'd7};
        start_battle = 1'b1; step(); start_battle = 1'b0; step();
        n_cmp++; if ({move_sel, result} !== 3'b000) begin n_fail++; $display("FAIL loss_start_clear: got %0b want 000", {move_sel, result}); end
        n_cmp++; if ({my_hp, enemy_hp} !== {8'd40, 8'd96}) begin n_fail++; $display("FAIL loss_start_hp: got %0h want %0h", {my_hp, enemy_hp}, {8'd40, 8'd96}); end
        for (int i = 0; i < 7; i++) begin
            press_key(KEY_ENTER); step(); enemy_phase(wants[i]);
            n_cmp++; if ({my_cur, my_hp} !== {exp_cur[i], exp_chk[i]}) begin n_fail++; $display("FAIL loss_chk%0d: got %0h want %0h", i, {my_cur, my_hp}, {exp_cur[i], exp_chk[i]}); end
            if (i < 6) begin
                step();
                n_cmp++; if (my_hp !== exp_sel[i]) begin n_fail++; $display("FAIL loss_sel%0d: got %0d want %0d", i, my_hp, exp_sel[i]); end
            end
        end
        step();
        n_cmp++; if ({end_battle, result, my_hp, enemy_hp} !== {2'b10, 8'd0, 8'd40}) begin n_fail++; $display("FAIL loss_done: got %0h want %0h", {end_battle, result, my_hp, enemy_hp}, {2'b10, 8'd0, 8'd40}); end
        step();
        n_cmp++; if (end_battle !== 1'b0) begin n_fail++; $display("FAIL loss_pulse_len: got %0b want 0", end_battle); end
    endtask

    task automatic test_delay_reset();
        logic [7:0] nxt;
        logic seen;
        int guard;
        start_battle = 1'b1; step(); start_battle = 1'b0; step();
        press_key(KEY_D); press_key(KEY_ENTER);
        n_cmp++; if (enemy_hp !== 8'd84) begin n_fail++; $display("FAIL dly_ehp: got %0d want 84", enemy_hp); end
        frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
        for (int i = 0; i < 2; i++) begin
            frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
        end
        n_cmp++; if ({turn, my_hp} !== {1'b1, 8'd40}) begin n_fail++; $display("FAIL dly_entry_tick: got %0h want %0h", {turn, my_hp}, {1'b1, 8'd40}); end
        guard = 0;
        nxt = lfsr_next(m_lfsr);
        while ((nxt[1:0] != 2'd2) && (guard < 600)) begin
            step(); guard++; nxt = lfsr_next(m_lfsr);
        end
        n_cmp++; if ({turn, my_hp} !== {1'b1, 8'd40}) begin n_fail++; $display("FAIL dly_two_ticks: got %0h want %0h", {turn, my_hp}, {1'b1, 8'd40}); end
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        n_cmp++; if ({turn, my_hp} !== {1'b1, 8'd40}) begin n_fail++; $display("FAIL dly_hitp: got %0h want %0h", {turn, my_hp}, {1'b1, 8'd40}); end
        step();
        n_cmp++; if (my_hp !== 8'd24) begin n_fail++; $display("FAIL dly_chkp_hp: got %0d want 24", my_hp); end
        step();
        press_key(KEY_ENTER); step();
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        #2 Reset = 1'b1;
        #1;
        n_cmp++; if ({my_hp, enemy_hp, move_sel} !== 18'd0) begin n_fail++; $display("FAIL dly_rst_vals: got %0h want 0", {my_hp, enemy_hp, move_sel}); end
        n_cmp++; if ({turn, end_battle, result, my_cur, enemy_cur} !== 7'd0) begin n_fail++; $display("FAIL dly_rst_flags: got %0h want 0", {turn, end_battle, result, my_cur, enemy_cur}); end
        seen = 1'b0;
        repeat (2) begin step(); seen = seen | end_battle; end
        Reset = 1'b0;
        repeat (10) begin step(); seen = seen | end_battle; end
        n_cmp++; if ({seen, turn, my_hp} !== 10'd0) begin n_fail++; $display("FAIL dly_post_rst: got %0h want 0", {seen, turn, my_hp}); end
        start_battle = 1'b1; step(); start_battle = 1'b0; step();
        n_cmp++; if ({my_hp, enemy_hp} !== {8'd40, 8'd96}) begin n_fail++; $display("FAIL dly_restart: got %0h want %0h", {my_hp, enemy_hp}, {8'd40, 8'd96}); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_player_attack();
        test_cursor();
        test_enemy_faint_win();
        test_saturation_loss();
        test_delay_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
